// File: rtl/countdown_display_controller.sv
// Irrigation timer core: BCD MM:SS countdown with a time-multiplexed 4-bit
// digit code bus that drives the 7-segment decoder, and an "Erro" fault display.
module countdown_display_controller #(
    parameter int TICKS_PER_SECOND = 50_000_000,
    parameter int SCAN_DIVIDER     = 50_000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_preset,
    input  logic        i_load,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_clear,
    input  logic        i_error_in,
    output logic [3:0]  o_data,
    output logic [3:0]  o_digit_select,
    output logic        o_running,
    output logic        o_done
);

    localparam int TICK_W = (TICKS_PER_SECOND > 2) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam int SCAN_W = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SECOND - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIVIDER - 1);

    localparam logic [3:0] CODE_E = 4'b1100;
    localparam logic [3:0] CODE_R = 4'b1110;
    localparam logic [3:0] CODE_O = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUNNING,
        S_PAUSED,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [15:0]         r_count;
    logic [15:0]         w_next_count;
    logic [15:0]         w_dec_count;
    logic [TICK_W-1:0]   r_tick;
    logic [TICK_W-1:0]   w_next_tick;
    logic                w_tick_wrap;
    logic                w_preset_ok;
    logic                w_pause_only;
    logic [SCAN_W-1:0]   r_scan_div;
    logic [SCAN_W-1:0]   w_next_scan_div;
    logic [1:0]          r_scan_idx;
    logic [1:0]          w_next_scan_idx;
    logic [3:0]          r_data;
    logic [3:0]          r_digit_sel;
    logic                r_running;
    logic                r_done;

    // A preset is a legal time only if every nibble is a decimal digit and
    // the tens-of-seconds digit is at most 5.
    function automatic logic preset_valid(input logic [15:0] p);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (p[k*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        if (p[7:4] > 4'd5) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [15:0] bcd_decrement(input logic [15:0] v);
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        {m1, m0, s1, s0} = v;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    function automatic logic [3:0] digit_code(input logic is_err,
                                              input logic [15:0] cnt,
                                              input logic [1:0] idx);
        logic [3:0] code;
        if (is_err) begin
            case (idx)
                2'd3:    code = CODE_E;
                2'd2:    code = CODE_R;
                2'd1:    code = CODE_R;
                default: code = CODE_O;
            endcase
        end else begin
            code = cnt[{idx, 2'b00} +: 4];
        end
        return code;
    endfunction

    assign w_dec_count  = bcd_decrement(r_count);
    assign w_tick_wrap  = (r_tick == TICK_LAST);
    assign w_preset_ok  = preset_valid(i_preset);
    assign w_pause_only = i_pause && !i_start;

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_tick  = r_tick;
        if (i_error_in) begin
            w_next_state = S_ERROR;
        end else begin
            case (r_state)
                S_ERROR: begin
                    if (i_clear) begin
                        w_next_state = S_IDLE;
                        w_next_count = 16'h0000;
                        w_next_tick  = '0;
                    end
                end
                S_IDLE: begin
                    if (i_clear) begin
                        w_next_count = 16'h0000;
                        w_next_tick  = '0;
                    end else if (i_load) begin
                        if (w_preset_ok) begin
                            w_next_count = i_preset;
                            w_next_tick  = '0;
                        end else begin
                            w_next_state = S_ERROR;
                        end
                    end else if (i_start && (r_count != 16'h0000)) begin
                        w_next_state = S_RUNNING;
                    end
                end
                S_RUNNING: begin
                    // A second boundary is honoured even on a pause edge; done wins over pause.
                    if (i_clear) begin
                        w_next_state = S_IDLE;
                        w_next_count = 16'h0000;
                        w_next_tick  = '0;
                    end else if (w_tick_wrap) begin
                        w_next_tick  = '0;
                        w_next_count = w_dec_count;
                        if (w_dec_count == 16'h0000) begin
                            w_next_state = S_DONE;
                        end else if (w_pause_only) begin
                            w_next_state = S_PAUSED;
                        end
                    end else if (w_pause_only) begin
                        w_next_state = S_PAUSED;
                    end else begin
                        w_next_tick = r_tick + 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (i_clear) begin
                        w_next_state = S_IDLE;
                        w_next_count = 16'h0000;
                        w_next_tick  = '0;
                    end else if (i_load) begin
                        if (w_preset_ok) begin
                            w_next_state = S_IDLE;
                            w_next_count = i_preset;
                            w_next_tick  = '0;
                        end else begin
                            w_next_state = S_ERROR;
                        end
                    end else if (i_start) begin
                        w_next_state = S_RUNNING;
                    end
                end
                S_DONE: begin
                    if (i_clear) begin
                        w_next_state = S_IDLE;
                        w_next_count = 16'h0000;
                        w_next_tick  = '0;
                    end else if (i_load) begin
                        if (w_preset_ok) begin
                            w_next_state = S_IDLE;
                            w_next_count = i_preset;
                            w_next_tick  = '0;
                        end else begin
                            w_next_state = S_ERROR;
                        end
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_count = 16'h0000;
                    w_next_tick  = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next_scan_div = r_scan_div + 1'b1;
        w_next_scan_idx = r_scan_idx;
        if (r_scan_div == SCAN_LAST) begin
            w_next_scan_div = '0;
            w_next_scan_idx = r_scan_idx + 2'd1;
        end
    end

    // Display outputs are built from next-cycle values so data and digit
    // select land on the same edge as the state, count and scan index.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= 16'h0000;
            r_tick      <= '0;
            r_scan_div  <= '0;
            r_scan_idx  <= 2'd0;
            r_data      <= 4'b0000;
            r_digit_sel <= 4'b1110;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_next_count;
            r_tick      <= w_next_tick;
            r_scan_div  <= w_next_scan_div;
            r_scan_idx  <= w_next_scan_idx;
            r_data      <= digit_code(w_next_state == S_ERROR, w_next_count, w_next_scan_idx);
            r_digit_sel <= ~(4'b0001 << w_next_scan_idx);
            r_running   <= (w_next_state == S_RUNNING);
            r_done      <= (w_next_state == S_DONE);
        end
    end

    assign o_data         = r_data;
    assign o_digit_select = r_digit_sel;
    assign o_running      = r_running;
    assign o_done         = r_done;

endmodule
